// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stall encoding, default widths, NOP address,
// EX/MEM payload field offsets and the stage action decode.
package pipe_pkg;

  typedef enum logic {
    NoStop = 1'b0,
    Stop   = 1'b1
  } stall_e;

  localparam int unsigned DEFAULT_STALL_W = 6;
  localparam logic [4:0]  NOP_REG_ADDR    = 5'b00000;

  // EX/MEM payload packing, LSB first: wd, wreg, wdata, whilo, hi/lo
  localparam int unsigned WD_LSB    = 0;
  localparam int unsigned WD_W      = 5;
  localparam int unsigned WREG_LSB  = WD_LSB + WD_W;
  localparam int unsigned WDATA_LSB = WREG_LSB + 1;
  localparam int unsigned WDATA_W   = 32;
  localparam int unsigned WHILO_LSB = WDATA_LSB + WDATA_W;
  localparam int unsigned HILO_LSB  = WHILO_LSB + 1;
  localparam int unsigned HILO_W    = 31;

  typedef enum logic [1:0] {
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_ADVANCE,
    ACT_HOLD
  } stage_act_e;

  // Priority: flush, then bubble, advance, hold
  function automatic stage_act_e stage_act(input logic flush,
                                           input logic stall_cur,
                                           input logic stall_nxt);
    if (flush)
      return ACT_FLUSH;
    else if (stall_cur == Stop && stall_nxt == NoStop)
      return ACT_BUBBLE;
    else if (stall_cur == NoStop)
      return ACT_ADVANCE;
    else
      return ACT_HOLD;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst || clr)
      r_q <= '0;
    else if (inc && r_q != '1)
      r_q <= r_q + 1'b1;
  end

  assign q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with flush/bubble/advance/hold control and a
// multi-cycle carry path. Optional perf counters under PIPE_STAGE_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 70,
  parameter int CARRY_W   = 66,
  parameter int STALL_W   = DEFAULT_STALL_W,
  parameter int STAGE     = 3,
  parameter int HOLD_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall_i,
  input  logic                 flush_i,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [CARRY_W-1:0]   carry_in,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CARRY_W-1:0]   carry_out,
`ifdef PIPE_STAGE_PERF_EN
  output logic [31:0]          bubble_cnt_o,
  output logic [31:0]          stall_cnt_o,
`endif
  output logic [HOLD_W-1:0]    hold_cycles_o
);

  if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE must be in 0..STALL_W-2");
  end

  stage_act_e             w_act;
  logic                   w_unused_stall;
  logic                   r_valid;
  logic [PAYLOAD_W-1:0]   r_payload;
  logic [CARRY_W-1:0]     r_carry;

  assign w_act          = stage_act(flush_i, stall_i[STAGE], stall_i[STAGE+1]);
  assign w_unused_stall = ^stall_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
      r_carry   <= '0;
    end else begin
      case (w_act)
        ACT_FLUSH: begin
          r_valid   <= 1'b0;
          r_payload <= '0;
          r_carry   <= '0;
        end
        ACT_BUBBLE: begin
          r_valid   <= 1'b0;
          r_payload <= '0;
          r_carry   <= carry_in;
        end
        ACT_ADVANCE: begin
          r_valid   <= in_valid;
          r_payload <= in_payload;
          r_carry   <= '0;
        end
        default: begin
          r_carry   <= carry_in;
        end
      endcase
    end
  end

  assign out_valid   = r_valid;
  assign out_payload = r_payload;
  assign carry_out   = r_carry;

  sat_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_act == ACT_BUBBLE || w_act == ACT_HOLD),
    .clr (w_act == ACT_FLUSH || w_act == ACT_ADVANCE),
    .q   (hold_cycles_o)
  );

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_act == ACT_BUBBLE) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (w_act == ACT_HOLD)   r_stall_cnt  <= r_stall_cnt + 32'd1;
    end
  end

  assign bubble_cnt_o = r_bubble_cnt;
  assign stall_cnt_o  = r_stall_cnt;
`endif

endmodule
